// File: rtl/user_io_pkg.sv
// Shared types and constants for the User IO <-> AXI-Stream lane channel.
package user_io_pkg;

    localparam int         AXI_DW   = 64;
    localparam logic [7:0] KEEP_ALL = 8'hFF;

    // Enumerator names carry a TX_/RX_ prefix because both enums share this scope.
    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_ASM,
        RX_DISCARD
    } rx_state_t;

    // Number of AXI beats needed to carry one user word.
    function automatic int beats(input int width);
        return width / AXI_DW;
    endfunction

endpackage

// File: rtl/user_io_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a synchronous flush.
// A push and a pop in the same cycle both succeed, even when the FIFO is full.
module user_io_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full, empty, do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and count update; flush wins over any access in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; no reset needed since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/user_io_axi_chan.sv
// Single-lane User IO <-> AXI-Stream channel: request words are serialised into
// tlast-framed packets of 64-bit beats, RX packets are reassembled into response
// words. Optional error counter port o_err_cnt under USER_IO_AXI_ERRCNT_EN.
//
//  state       | meaning
//  TX_IDLE     | no packet in flight; load next request word when channel is up
//  TX_SEND     | presenting beat beat_q of word_q; advances on tvalid & tready
//  RX_IDLE     | waiting for beat 0 of a packet
//  RX_ASM      | collecting beats 1..N-1 into the assembly register
//  RX_DISCARD  | overlong packet; drop beats until the next tlast
module user_io_axi_chan
    import user_io_pkg::*;
#(
    parameter int UIO_PORTS_WIDTH = 128,
    parameter int RQ_DEPTH        = 16,
    parameter int RS_DEPTH        = 8,
    parameter int AFULL_SLACK     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_stat_chan_up,
    input  logic                       uio_rq_vld,
    input  logic [UIO_PORTS_WIDTH-1:0] uio_rq_data,
    output logic                       uio_rq_afull,
    output logic [7:0]                 o_s_axi_tx_tkeep,
    output logic [63:0]                o_s_axi_tx_tdata,
    output logic                       o_s_axi_tx_tlast,
    output logic                       o_s_axi_tx_tvalid,
    input  logic                       i_s_axi_tx_tready,
    input  logic [7:0]                 i_m_axi_rx_tkeep,
    input  logic [63:0]                i_m_axi_rx_tdata,
    input  logic                       i_m_axi_rx_tlast,
    input  logic                       i_m_axi_rx_tvalid,
    output logic                       uio_rs_vld,
    output logic [UIO_PORTS_WIDTH-1:0] uio_rs_data,
    input  logic                       uio_rs_afull
`ifdef USER_IO_AXI_ERRCNT_EN
    ,output logic [15:0]               o_err_cnt
`endif
);

    localparam int             N         = beats(UIO_PORTS_WIDTH);
    localparam int             BW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0]  LAST_BEAT = BW'(N - 1);
    localparam int             RQ_CW     = $clog2(RQ_DEPTH) + 1;
    localparam int             RS_CW     = $clog2(RS_DEPTH) + 1;

    logic                       rq_wr, rq_pop, rq_empty;
    logic [UIO_PORTS_WIDTH-1:0] rq_rd_data;
    logic [RQ_CW-1:0]           rq_count;
    logic                       rs_push, rs_pop, rs_empty;
    logic [UIO_PORTS_WIDTH-1:0] rs_word, rs_rd_data;
    logic [RS_CW-1:0]           rs_count;

    tx_state_t                  tx_q, tx_d;
    logic [UIO_PORTS_WIDTH-1:0] word_q, word_d;
    logic [BW-1:0]              beat_q, beat_d;
    rx_state_t                  rx_q, rx_d;
    logic [UIO_PORTS_WIDTH-1:0] asm_q, asm_d;
    logic [BW-1:0]              rbeat_q, rbeat_d;
    logic                       uio_rq_afull_q, uio_rq_afull_d;
    logic                       uio_rs_vld_q, uio_rs_vld_d;
    logic [UIO_PORTS_WIDTH-1:0] uio_rs_data_q, uio_rs_data_d;

    // While the channel is down the request FIFO is held empty and writes are ignored.
    assign rq_wr    = uio_rq_vld && i_stat_chan_up;
    assign rq_empty = (rq_count == '0);
    assign rs_empty = (rs_count == '0);
    assign rs_pop   = !rs_empty && !uio_rs_afull;

    user_io_sync_fifo #(.WIDTH(UIO_PORTS_WIDTH), .DEPTH(RQ_DEPTH)) u_rq_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (!i_stat_chan_up),
        .wr_en   (rq_wr),
        .wr_data (uio_rq_data),
        .rd_en   (rq_pop),
        .rd_data (rq_rd_data),
        .count   (rq_count)
    );

    user_io_sync_fifo #(.WIDTH(UIO_PORTS_WIDTH), .DEPTH(RS_DEPTH)) u_rs_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (1'b0),
        .wr_en   (rs_push),
        .wr_data (rs_word),
        .rd_en   (rs_pop),
        .rd_data (rs_rd_data),
        .count   (rs_count)
    );

    // TX next state: load a word, step beats on handshake, reload on the last beat.
    always_comb begin
        tx_d   = tx_q;
        word_d = word_q;
        beat_d = beat_q;
        rq_pop = 1'b0;
        if (!i_stat_chan_up) begin
            tx_d   = TX_IDLE;
            beat_d = '0;
        end else begin
            case (tx_q)
                TX_IDLE: begin
                    if (!rq_empty) begin
                        rq_pop = 1'b1;
                        word_d = rq_rd_data;
                        beat_d = '0;
                        tx_d   = TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (i_s_axi_tx_tready) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_d = '0;
                            if (!rq_empty) begin
                                rq_pop = 1'b1;
                                word_d = rq_rd_data;
                            end else begin
                                tx_d = TX_IDLE;
                            end
                        end else begin
                            beat_d = beat_q + BW'(1);
                        end
                    end
                end
                default: tx_d = TX_IDLE;
            endcase
        end
    end

    // TX outputs are decoded from registered state only.
    always_comb begin
        o_s_axi_tx_tvalid = (tx_q == TX_SEND);
        o_s_axi_tx_tkeep  = '0;
        o_s_axi_tx_tdata  = '0;
        o_s_axi_tx_tlast  = 1'b0;
        if (tx_q == TX_SEND) begin
            o_s_axi_tx_tkeep = KEEP_ALL;
            o_s_axi_tx_tdata = word_q[int'(beat_q)*AXI_DW +: AXI_DW];
            o_s_axi_tx_tlast = (beat_q == LAST_BEAT);
        end
    end

    // RX framing: assemble beats, push complete words, drop malformed packets.
    always_comb begin
        rx_d    = rx_q;
        rbeat_d = rbeat_q;
        asm_d   = asm_q;
        rs_push = 1'b0;
        rs_word = asm_q;
        rs_word[int'(rbeat_q)*AXI_DW +: AXI_DW] = i_m_axi_rx_tdata;
        if (!i_stat_chan_up) begin
            rx_d    = RX_IDLE;
            rbeat_d = '0;
            asm_d   = '0;
        end else if (i_m_axi_rx_tvalid) begin
            case (rx_q)
                RX_IDLE, RX_ASM: begin
                    if (i_m_axi_rx_tkeep != KEEP_ALL) begin
                        rx_d    = RX_IDLE;
                        rbeat_d = '0;
                    end else if (i_m_axi_rx_tlast) begin
                        rs_push = (rbeat_q == LAST_BEAT);
                        rx_d    = RX_IDLE;
                        rbeat_d = '0;
                    end else if (rbeat_q == LAST_BEAT) begin
                        rx_d    = RX_DISCARD;
                        rbeat_d = '0;
                    end else begin
                        asm_d   = rs_word;
                        rbeat_d = rbeat_q + BW'(1);
                        rx_d    = RX_ASM;
                    end
                end
                RX_DISCARD: begin
                    if (i_m_axi_rx_tlast) rx_d = RX_IDLE;
                end
                default: rx_d = RX_IDLE;
            endcase
        end
    end

    // Registered status and response outputs; response data holds between pops.
    always_comb begin
        uio_rq_afull_d = (rq_count >= RQ_CW'(RQ_DEPTH - AFULL_SLACK)) || !i_stat_chan_up;
        uio_rs_vld_d   = rs_pop;
        uio_rs_data_d  = rs_pop ? rs_rd_data : uio_rs_data_q;
    end

    // State registers for both FSMs and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q           <= TX_IDLE;
            word_q         <= '0;
            beat_q         <= '0;
            rx_q           <= RX_IDLE;
            asm_q          <= '0;
            rbeat_q        <= '0;
            uio_rq_afull_q <= 1'b1;
            uio_rs_vld_q   <= 1'b0;
            uio_rs_data_q  <= '0;
        end else begin
            tx_q           <= tx_d;
            word_q         <= word_d;
            beat_q         <= beat_d;
            rx_q           <= rx_d;
            asm_q          <= asm_d;
            rbeat_q        <= rbeat_d;
            uio_rq_afull_q <= uio_rq_afull_d;
            uio_rs_vld_q   <= uio_rs_vld_d;
            uio_rs_data_q  <= uio_rs_data_d;
        end
    end

    assign uio_rq_afull = uio_rq_afull_q;
    assign uio_rs_vld   = uio_rs_vld_q;
    assign uio_rs_data  = uio_rs_data_q;

`ifdef USER_IO_AXI_ERRCNT_EN
    logic        rq_ovf, rs_ovf, rx_frame_err;
    logic [16:0] err_sum;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Framing faults and RS overflow are mutually exclusive; an RQ drop can coincide.
    always_comb begin
        rq_ovf       = rq_wr && (rq_count == RQ_CW'(RQ_DEPTH)) && !rq_pop;
        rs_ovf       = rs_push && (rs_count == RS_CW'(RS_DEPTH)) && !rs_pop;
        rx_frame_err = i_stat_chan_up && i_m_axi_rx_tvalid && (rx_q != RX_DISCARD) &&
                       ((i_m_axi_rx_tkeep != KEEP_ALL) ||
                        (i_m_axi_rx_tlast && (rbeat_q != LAST_BEAT)) ||
                        (!i_m_axi_rx_tlast && (rbeat_q == LAST_BEAT)));
        err_sum      = {1'b0, err_cnt_q} + 17'(rq_ovf) + 17'(rs_ovf || rx_frame_err);
        err_cnt_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_user_io_axi_chan.sv
module tb_user_io_axi_chan;
    localparam int W     = 256;
    localparam int N     = W / 64;
    localparam int RQD   = 16;
    localparam int RSD   = 8;
    localparam int SLACK = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          chan_up = 1'b0;
    logic          rq_vld = 1'b0;
    logic [W-1:0]  rq_data = '0;
    logic          rq_afull;
    logic [7:0]    tx_keep;
    logic [63:0]   tx_data;
    logic          tx_last, tx_valid;
    logic          tx_ready = 1'b0;
    logic [7:0]    rx_keep = 8'hFF;
    logic [63:0]   rx_data = '0;
    logic          rx_last = 1'b0, rx_valid = 1'b0;
    logic          rs_vld;
    logic [W-1:0]  rs_data;
    logic          rs_afull = 1'b0;
`ifdef USER_IO_AXI_ERRCNT_EN
    logic [15:0]   err_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic [W-1:0] last_rs = '0;

    always #5 clk = ~clk;

    user_io_axi_chan #(
        .UIO_PORTS_WIDTH(W), .RQ_DEPTH(RQD), .RS_DEPTH(RSD), .AFULL_SLACK(SLACK)
    ) dut (
        .clk(clk), .reset(reset), .i_stat_chan_up(chan_up),
        .uio_rq_vld(rq_vld), .uio_rq_data(rq_data), .uio_rq_afull(rq_afull),
        .o_s_axi_tx_tkeep(tx_keep), .o_s_axi_tx_tdata(tx_data),
        .o_s_axi_tx_tlast(tx_last), .o_s_axi_tx_tvalid(tx_valid),
        .i_s_axi_tx_tready(tx_ready),
        .i_m_axi_rx_tkeep(rx_keep), .i_m_axi_rx_tdata(rx_data),
        .i_m_axi_rx_tlast(rx_last), .i_m_axi_rx_tvalid(rx_valid),
        .uio_rs_vld(rs_vld), .uio_rs_data(rs_data), .uio_rs_afull(rs_afull)
`ifdef USER_IO_AXI_ERRCNT_EN
        , .o_err_cnt(err_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model (queues, beat index) ----------------
    logic [W-1:0] m_rq[$];
    logic [W-1:0] m_rs[$];
    bit           m_busy;
    logic [W-1:0] m_word;
    int           m_beat;
    bit           m_afull;
    int           m_rx_cnt;
    bit           m_disc;
    logic [W-1:0] m_asm;
    bit           m_rs_vld;
    logic [W-1:0] m_rs_data;
    int           m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rq.delete(); m_rs.delete();
            m_busy = 0; m_beat = 0; m_word = '0; m_afull = 1;
            m_rx_cnt = 0; m_disc = 0; m_asm = '0;
            m_rs_vld = 0; m_rs_data = '0; m_err = 0;
        end else begin : step
            int rq_n, rs_n;
            bit popped, rs_popped, push_rs;
            rq_n = m_rq.size();
            rs_n = m_rs.size();
            push_rs = 0;
            m_afull = (rq_n >= RQD - SLACK) || !chan_up;
            if (!chan_up) begin
                m_rq.delete();
                m_busy = 0; m_rx_cnt = 0; m_disc = 0;
            end else begin
                popped = 0;
                if (m_busy && tx_ready) begin
                    m_beat++;
                    if (m_beat == N) m_busy = 0;
                end
                if (!m_busy && rq_n > 0) begin
                    m_word = m_rq.pop_front(); m_busy = 1; m_beat = 0; popped = 1;
                end
                if (rq_vld) begin
                    if (rq_n < RQD || popped) m_rq.push_back(rq_data);
                    else m_err++;
                end
                if (rx_valid) begin
                    if (m_disc) begin
                        if (rx_last) m_disc = 0;
                    end else if (rx_keep != 8'hFF) begin
                        m_err++; m_rx_cnt = 0;
                    end else begin
                        m_asm[m_rx_cnt*64 +: 64] = rx_data;
                        if (rx_last) begin
                            if (m_rx_cnt == N-1) push_rs = 1; else m_err++;
                            m_rx_cnt = 0;
                        end else if (m_rx_cnt == N-1) begin
                            m_err++; m_disc = 1; m_rx_cnt = 0;
                        end else m_rx_cnt++;
                    end
                end
            end
            rs_popped = 0;
            if (rs_n > 0 && !rs_afull) begin
                m_rs_data = m_rs.pop_front(); m_rs_vld = 1; rs_popped = 1;
            end else m_rs_vld = 0;
            if (push_rs) begin
                if (rs_n < RSD || rs_popped) m_rs.push_back(m_asm);
                else m_err++;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [63:0] exp_data;
        exp_data = '0;
        if (m_busy) exp_data = m_word[m_beat*64 +: 64];
        chk("tvalid", tx_valid, m_busy);
        chk("tlast", tx_last, m_busy && (m_beat == N-1));
        chk("tkeep", tx_keep, m_busy ? 8'hFF : 8'h00);
        chk("tdata", tx_data, exp_data);
        chk("rq_afull", rq_afull, m_afull);
        chk("rs_vld", rs_vld, m_rs_vld);
        chk("rs_data", rs_data, m_rs_data);
`ifdef USER_IO_AXI_ERRCNT_EN
        chk("err_cnt", err_cnt, (m_err > 65535) ? 65535 : m_err);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
        if (rs_vld) begin pulses++; last_rs = rs_data; end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic send_rx(input logic [63:0] base, input int nb);
        for (int b = 0; b < nb; b++) begin
            rx_valid = 1; rx_keep = 8'hFF; rx_data = base | 64'(b); rx_last = (b == nb-1);
            tick();
        end
        rx_valid = 0; rx_last = 0;
    endtask

    initial begin
        logic [W-1:0] lit;
        int hs, last_at, down_cnt, rx_pos;

        #1 reset = 1;
        #2;
        chk("rst_afull", rq_afull, 1'b1);
        chk("rst_tvalid", tx_valid, 1'b0);
        chk("rst_tlast", tx_last, 1'b0);
        chk("rst_tkeep", tx_keep, 8'h00);
        chk("rst_tdata", tx_data, 64'h0);
        chk("rst_rs_vld", rs_vld, 1'b0);
        chk("rst_rs_data", rs_data, '0);
        repeat (3) tick();
        reset = 0; chan_up = 1; tx_ready = 1;
        repeat (3) tick();

        // 1: single request, continuous tready, LSB beat first
        lit = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        tick(); rq_vld = 1; rq_data = lit;
        tick(); rq_vld = 0;
        chk("lat_t1_idle", tx_valid, 1'b0);
        tick();
        chk("b0_valid", tx_valid, 1'b1);
        chk("b0_data", tx_data, 64'h1111_1111_1111_1111);
        chk("b0_last", tx_last, 1'b0);
        tick(); chk("b1_data", tx_data, 64'h2222_2222_2222_2222);
        tick(); chk("b2_data", tx_data, 64'h3333_3333_3333_3333);
        tick();
        chk("b3_data", tx_data, 64'h4444_4444_4444_4444);
        chk("b3_last", tx_last, 1'b1);
        chk("b3_keep", tx_keep, 8'hFF);
        tick(); chk("after_pkt", tx_valid, 1'b0);

        // 2: tready toggling 1-0-1-0
        tick(); rq_vld = 1; rq_data = rand_word(); tx_ready = 0;
        tick(); rq_vld = 0;
        hs = 0; last_at = 0;
        for (int i = 0; i < 12; i++) begin
            tick(); tx_ready = (i % 2 == 0);
            if (tx_valid && tx_ready) begin
                hs++;
                if (tx_last) last_at = (last_at == 0) ? hs : -1;
            end
        end
        chk("toggle_hs", 32'(hs), 32'd4);
        chk("toggle_last", 32'(last_at), 32'd4);

        // 3: 20 writes with tready=0; one word leaves into TX, 16 fill FIFO, 3 dropped
        tx_ready = 0;
        repeat (3) tick();
        for (int i = 0; i < 20; i++) begin tick(); rq_vld = 1; rq_data = rand_word(); end
        tick(); rq_vld = 0;
        tick();
        chk("fill_afull", rq_afull, 1'b1);
`ifdef USER_IO_AXI_ERRCNT_EN
        chk("fill_err", err_cnt, 16'd3);
`endif
        tx_ready = 1;
        repeat (17*N + 10) tick();

        // 4: RX framing errors around good packets
        pulses = 0;
        send_rx(64'hB000_0000_0000_0000, 4);
        send_rx(64'hD000_0000_0000_0000, 1);
        send_rx(64'hE000_0000_0000_0000, 5);
        rx_valid = 1; rx_keep = 8'h0F; rx_last = 1; rx_data = 64'h1; tick();
        rx_valid = 0; rx_last = 0; rx_keep = 8'hFF;
        send_rx(64'hC000_0000_0000_0000, 4);
        repeat (4) tick();
        chk("rx_pulses", 32'(pulses), 32'd2);
        chk("rx_word_hi", last_rs[255:192], 64'hC000_0000_0000_0003);
        chk("rx_word_lo", last_rs[63:0], 64'hC000_0000_0000_0000);
`ifdef USER_IO_AXI_ERRCNT_EN
        chk("rx_err", err_cnt, 16'd6);
`endif

        // 5: RS overflow under uio_rs_afull, then ordered drain
        rs_afull = 1; pulses = 0;
        for (int p = 0; p < 10; p++) send_rx(64'hA000_0000_0000_0000 | 64'(p << 8), 4);
        repeat (3) tick();
        chk("rs_held", 32'(pulses), 32'd0);
        rs_afull = 0;
        repeat (12) tick();
        chk("rs_drain", 32'(pulses), 32'd8);
        chk("rs_last_word", last_rs[255:192], 64'hA000_0000_0000_0703);
`ifdef USER_IO_AXI_ERRCNT_EN
        chk("rs_err", err_cnt, 16'd8);
`endif

        // 6: channel drop during beat 1
        tx_ready = 1;
        lit = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
        tick(); rq_vld = 1; rq_data = lit;
        tick(); rq_vld = 0;
        tick(); chk("cd_b0", tx_data, 64'h5555_5555_5555_5555);
        tick(); chk("cd_b1", tx_data, 64'h6666_6666_6666_6666); chan_up = 0;
        tick();
        chk("cd_tvalid", tx_valid, 1'b0);
        chk("cd_afull", rq_afull, 1'b1);
        rq_vld = 1; rq_data = rand_word();
        tick(); rq_vld = 0;
        repeat (2) tick();
        chan_up = 1;
        repeat (2) tick();
        chk("cu_afull", rq_afull, 1'b0);
        chk("cu_idle", tx_valid, 1'b0);
        lit = {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB,
               64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999};
        tick(); rq_vld = 1; rq_data = lit;
        tick(); rq_vld = 0;
        tick();
        chk("cu_b0_valid", tx_valid, 1'b1);
        chk("cu_b0_data", tx_data, 64'h9999_9999_9999_9999);
        repeat (8) tick();

        // 7: randomized traffic against the model
        down_cnt = 0; rx_pos = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (down_cnt > 0) begin
                down_cnt--;
                chan_up = (down_cnt == 0);
            end else if ($urandom_range(0, 399) == 0) begin
                chan_up = 0; down_cnt = $urandom_range(1, 6);
            end
            rq_vld   = ($urandom_range(0, 2) == 0);
            rq_data  = rand_word();
            tx_ready = ($urandom_range(0, 9) < 7);
            rs_afull = ($urandom_range(0, 4) == 0);
            rx_valid = ($urandom_range(0, 3) != 0);
            rx_data  = {$urandom, $urandom};
            rx_keep  = ($urandom_range(0, 40) == 0) ? 8'($urandom) : 8'hFF;
            if (rx_pos == N-1) rx_last = ($urandom_range(0, 20) != 0);
            else               rx_last = ($urandom_range(0, 25) == 0);
            if (rx_valid) rx_pos = rx_last ? 0 : (rx_pos + 1) % 8;
        end
        rq_vld = 0; rx_valid = 0; rx_last = 0; rx_keep = 8'hFF;
        chan_up = 1; tx_ready = 1; rs_afull = 0;
        repeat (100) tick();

        // 8: asynchronous reset mid-packet
        tx_ready = 0;
        tick(); rq_vld = 1; rq_data = rand_word();
        tick(); rq_vld = 0;
        repeat (2) tick();
        chk("ar_pre_valid", tx_valid, 1'b1);
        #2 reset = 1;
        #1;
        chk("ar_tvalid", tx_valid, 1'b0);
        chk("ar_tdata", tx_data, 64'h0);
        chk("ar_tlast", tx_last, 1'b0);
        chk("ar_afull", rq_afull, 1'b1);
        repeat (2) tick();
        reset = 0; tx_ready = 1;
        repeat (6) tick();
        chk("ar_no_resume", tx_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
